// File: rtl/keystream_gen.sv
// rtl/keystream_gen.sv - LFSR keystream byte generator feeding a byte-XOR cipher stage
// Emits one byte per 9 cycles: 8 Galois LFSR steps (LSB first) then a valid/ready hold.

module keystream_lfsr_step (
  input  logic [15:0] state_i,
  output logic [15:0] next_o,
  output logic        bit_o
);
  // Galois form of x^16+x^14+x^13+x^11+1: feedback taps folded into 16'hB400
  assign bit_o  = state_i[0];
  assign next_o = (state_i >> 1) ^ (state_i[0] ? 16'hB400 : 16'h0000);
endmodule

module keystream_gen #(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [7:0]  key_byte,
  output logic [7:0]  byte_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GEN, VALID} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [7:0]  key_byte_q;
  logic [2:0]  shift_cnt_q;
  logic [7:0]  byte_count_q;
  logic        key_valid_q;
  logic        busy_q;

  logic [15:0] lfsr_d;
  logic        step_bit;
  logic [15:0] seed_d;

  keystream_lfsr_step u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_d),
    .bit_o   (step_bit)
  );

  // An all-zero seed would lock the LFSR at zero forever
  assign seed_d = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q      <= IDLE;
      lfsr_q       <= DEFAULT_SEED;
      key_byte_q   <= 8'h00;
      shift_cnt_q  <= 3'd0;
      byte_count_q <= 8'h00;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else if (seed_load) begin
      // Seeding aborts any byte in flight and wins over a same-edge handshake
      state_q      <= GEN;
      lfsr_q       <= seed_d;
      shift_cnt_q  <= 3'd0;
      byte_count_q <= 8'h00;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        GEN: begin
          lfsr_q                  <= lfsr_d;
          key_byte_q[shift_cnt_q] <= step_bit;
          shift_cnt_q             <= shift_cnt_q + 3'd1;
          if (shift_cnt_q == 3'd7) begin
            state_q     <= VALID;
            key_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        VALID: begin
          if (key_ready) begin
            state_q      <= GEN;
            shift_cnt_q  <= 3'd0;
            byte_count_q <= byte_count_q + 8'd1;
            key_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign key_valid  = key_valid_q;
  assign key_byte   = key_byte_q;
  assign byte_count = byte_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_keystream_gen.sv
// tb/tb_keystream_gen.sv - scoreboard bench for keystream_gen with a reference keystream model
// Driver pushes expected bytes on each seed; a negedge monitor pops and checks independently.

module tb_keystream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        key_ready;
  logic        key_valid;
  logic [7:0]  key_byte;
  logic [7:0]  byte_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];

  keystream_gen dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_byte   (key_byte),
    .byte_count (byte_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference keystream: repeated halving of the register, folding in the tap mask
  // whenever the discarded bit is one; the discarded bits form each byte LSB first.
  task automatic push_expected(input logic [15:0] seed);
    int s;
    int b;
    int byt;
    s = (seed == 16'h0000) ? 32'hACE1 : int'(seed);
    for (int n = 0; n < 300; n++) begin
      byt = 0;
      for (int k = 0; k < 8; k++) begin
        b = s % 2;
        s = s / 2;
        if (b == 1) s = s ^ 32'hB400;
        byt = byt + (b << k);
      end
      sb.push_back(8'(byt));
    end
  endtask

  // Monitor state
  bit         have_prev = 0;
  logic       p_rst, p_seed, p_valid, p_ready;
  logic [7:0] p_byte, p_count;
  bit         gen = 0;
  int         edges = 0;
  logic [7:0] exp_count = 8'h00;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (have_prev) begin
      if (p_rst) begin
        check("reset_state", {key_valid, busy, byte_count, key_byte}, {1'b0, 1'b0, 8'h00, 8'h00});
        gen = 0;
        exp_count = 8'h00;
      end else if (p_seed) begin
        check("seed_load", {key_valid, busy, byte_count}, {1'b0, 1'b1, 8'h00});
        gen = 1;
        edges = 1;
        exp_count = 8'h00;
      end else if (p_valid && p_ready) begin
        exp_count = exp_count + 8'd1;
        check("handshake", {key_valid, busy, byte_count}, {1'b0, 1'b1, exp_count});
        gen = 1;
        edges = 1;
      end else if (p_valid) begin
        check("hold", {key_valid, busy, byte_count, key_byte}, {1'b1, 1'b0, p_count, p_byte});
      end else if (gen) begin
        edges++;
        if (key_valid) begin
          check("latency", edges, 9);
          check("valid_state", {busy, byte_count}, {1'b0, exp_count});
          gen = 0;
        end else begin
          check("gen_state", {busy, byte_count}, {1'b1, exp_count});
          if (edges >= 9) begin
            check("latency_timeout", edges, 9);
            gen = 0;
          end
        end
      end else begin
        check("idle", {key_valid, busy}, {1'b0, 1'b0});
      end
    end
    p_rst   = rst;
    p_seed  = seed_load;
    p_valid = key_valid;
    p_ready = key_ready;
    p_byte  = key_byte;
    p_count = byte_count;
    if (!rst && !seed_load && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        exp_byte = sb.pop_front();
        check("key_byte", key_byte, exp_byte);
      end
    end
    have_prev = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    sb.delete();
    push_expected(s);
    tick();
    seed_load = 1'b0;
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 40; i++) begin
      if (key_valid) break;
      tick();
    end
    if (i == 40) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_in   = 16'h0000;
    key_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Known seed, streaming with ready held high
    key_ready = 1'b1;
    do_seed(16'h0001);
    repeat (60) tick();

    // Backpressure for 20 cycles after valid rises
    key_ready = 1'b0;
    wait_valid();
    repeat (20) tick();
    key_ready = 1'b1;
    repeat (20) tick();

    // Zero seed and its substitute
    do_seed(16'h0000);
    repeat (40) tick();
    do_seed(16'hACE1);
    repeat (40) tick();

    // Random ready with occasional re-seeding
    do_seed(16'($urandom));
    for (int i = 0; i < 400; i++) begin
      key_ready = 1'($urandom % 2);
      if ($urandom % 60 == 0) do_seed(16'($urandom));
      else tick();
    end

    // Seed on the same edge as a handshake
    key_ready = 1'b0;
    wait_valid();
    key_ready = 1'b1;
    do_seed(16'($urandom));
    repeat (40) tick();

    // Reset sampled on the 4th step, then reseed with the known seed
    do_seed(16'h1234);
    repeat (3) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    do_seed(16'h0001);
    repeat (30) tick();

    // byte_count wrap past 255
    do_seed(16'($urandom));
    repeat (260 * 9) tick();

    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keystream_gen.md
KEYSTREAM_GEN -- requirements
Module: keystream_gen

Interface
REQ-001 The module SHALL have one parameter: DEFAULT_SEED, default 16'hACE1, the LFSR value substituted for an all-zero seed.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port CLOCK_50, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 Port seed_load, input, 1 bit: single-cycle request to load seed_in and start generating.
REQ-006 Port seed_in, input, 16 bits: LFSR seed, sampled when seed_load is high.
REQ-007 Port key_ready, input, 1 bit: downstream byte-XOR stage accepts key_byte.
REQ-008 Port key_valid, output, 1 bit: key_byte holds a complete keystream byte.
REQ-009 Port key_byte, output, 8 bits: keystream byte that drives the key operand of the byte-XOR cipher stage.
REQ-010 Port byte_count, output, 8 bits: number of bytes accepted since the last seed_load.
REQ-011 Port busy, output, 1 bit: high while the FSM is in GEN.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GEN and VALID.
REQ-013 LFSR step (Galois, polynomial x^16+x^14+x^13+x^11+1) SHALL be: out = lfsr[0]; lfsr <= (lfsr >> 1) XOR (out ? 16'hB400 : 16'h0000).
REQ-014 In GEN, the block SHALL perform one LFSR step per cycle for 8 cycles, using a 3-bit shift counter.
REQ-015 The output bit of the k-th step (k = 0..7) SHALL be written to key_byte bit k (LSB first).
REQ-016 Transition IDLE -> GEN SHALL occur on the edge where seed_load = 1.
- On that edge: lfsr <= seed_in, or DEFAULT_SEED if seed_in == 16'h0000.
- On that edge: shift counter <= 0 and byte_count <= 0.
REQ-017 Transition GEN -> VALID SHALL occur on the edge that performs the 8th step; key_valid is high from the following cycle.
- Latency from the seed_load edge to key_valid high SHALL be 9 clock edges.
REQ-018 In VALID, key_byte and the lfsr SHALL hold their values until the handshake.
REQ-019 Handshake: on an edge with key_valid = 1 and key_ready = 1, the block SHALL:
- move to GEN;
- drive key_valid low from the next cycle;
- increment byte_count.
REQ-020 Sustained throughput SHALL be one byte per 9 cycles.
REQ-021 key_ready while key_valid = 0 SHALL be ignored.
REQ-022 The block SHALL never drop key_valid without a handshake, except on seed_load or RESET.
REQ-023 byte_count SHALL wrap from 8'hFF to 8'h00 without saturating.
REQ-024 A seed_load asserted in GEN or VALID SHALL abort the current byte and apply REQ-016.
- key_valid SHALL be low from the next cycle.
- seed_load SHALL take priority over a simultaneous handshake, so byte_count ends at 0.
REQ-025 While key_valid = 0, key_byte SHALL show the partially shifted byte; consumers SHALL qualify it with key_valid.
REQ-026 In IDLE, the lfsr SHALL hold and no steps SHALL occur.

Reset
REQ-027 RESET SHALL be sampled only on a clock edge and SHALL override every other input, including seed_load.
REQ-028 Reset values SHALL be:
- FSM = IDLE;
- lfsr = DEFAULT_SEED;
- key_byte = 8'h00, key_valid = 0, byte_count = 8'h00, busy = 0;
- shift counter = 0.
REQ-029 RESET asserted mid-GEN or in VALID SHALL discard the in-flight byte; no handshake SHALL complete on that edge.

Verification
REQ-030 Seed path: seed_load with seed_in = 16'h0001, key_ready = 1 -> first byte 8'h01 (lfsr 16'h0168), second byte 8'h68 (lfsr 16'h7C41); byte_count 1 after the first handshake, 2 after the second.
REQ-031 Zero seed: seed_load with seed_in = 16'h0000 -> byte sequence identical to seed_in = 16'hACE1.
REQ-032 Backpressure: key_ready = 0 for 20 cycles after key_valid rises -> key_valid stays 1, key_byte stays stable, busy = 0, byte_count unchanged.
REQ-033 Timing: key_valid rises exactly 9 edges after seed_load; with key_ready tied to 1, it pulses every 9 cycles.
REQ-034 Abort: seed_load on the same edge as a handshake -> byte_count = 0, and the next byte is computed from the new seed.
REQ-035 Reset: RESET asserted during the 4th GEN step -> next cycle FSM = IDLE, key_valid = 0, byte_count = 0; a later seed_load 16'h0001 produces 8'h01 again.
